// File: rtl/pio_capture_pkg.sv
// Shared constants for the pio_capture_in block: register map, edge-mode
// encodings and FIFO_STAT bit layout.
package pio_capture_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE = 3'd2;
    localparam logic [2:0] ADDR_POP  = 3'd3;
    localparam logic [2:0] ADDR_STAT = 3'd4;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int STAT_COUNT_W   = 7;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 16;

endpackage

// File: rtl/pio_snapshot_fifo.sv
// Snapshot FIFO with a combinational head output. A push while full is only
// accepted if a pop frees the slot in the same cycle; overflow is tracked outside.
module pio_snapshot_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = AW + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= din;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pio_capture_in.sv
// Avalon-MM input PIO: synchroniser, edge capture, maskable irq and a snapshot
// FIFO of the synchronised input word.
module pio_capture_in
    import pio_capture_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_RISE,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [DATA_W-1:0] in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] prev_q, sync_w, edge_vec;
    logic [DATA_W-1:0] mask_q, mask_d, edge_cap_q, edge_cap_d, edge_clr;
    logic              ovf_q, ovf_d;
    logic [31:0]       readdata_q, readdata_d, rd_word;
    logic              wr_en, rd_en, push, pop;
    logic [DATA_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full, fifo_empty;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q[gi] <= '0;
                end else if (gi == 0) begin
                    sync_q[gi] <= in_port;
                end else begin
                    sync_q[gi] <= sync_q[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign sync_w = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_MODE == EDGE_FALL) begin : g_fall
            assign edge_vec = ~sync_w & prev_q;
        end else if (EDGE_MODE == EDGE_ANY) begin : g_any
            assign edge_vec = sync_w ^ prev_q;
        end else begin : g_rise
            assign edge_vec = sync_w & ~prev_q;
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & read;
    assign push  = |(edge_vec & mask_q);
    assign pop   = rd_en && (address == ADDR_POP);

    pio_snapshot_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (sync_w),
        .dout    (fifo_dout),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        mask_d = mask_q;
        if (wr_en && address == ADDR_MASK) mask_d = writedata[DATA_W-1:0];

        // A new edge beats a same-cycle write-1-to-clear.
        edge_clr = '0;
        if (wr_en && address == ADDR_EDGE) edge_clr = writedata[DATA_W-1:0];
        edge_cap_d = (edge_cap_q & ~edge_clr) | edge_vec;

        ovf_d = ovf_q;
        if (wr_en && address == ADDR_STAT) ovf_d = 1'b0;
        if (push && fifo_full && !pop)     ovf_d = 1'b1;

        rd_word = '0;
        case (address)
            ADDR_DATA: rd_word[DATA_W-1:0] = sync_w;
            ADDR_MASK: rd_word[DATA_W-1:0] = mask_q;
            ADDR_EDGE: rd_word[DATA_W-1:0] = edge_cap_q;
            ADDR_POP:  rd_word[DATA_W-1:0] = fifo_empty ? '0 : fifo_dout;
            ADDR_STAT: begin
                rd_word[STAT_COUNT_W-1:0] = STAT_COUNT_W'(fifo_count);
                rd_word[STAT_EMPTY_BIT]   = fifo_empty;
                rd_word[STAT_FULL_BIT]    = fifo_full;
                rd_word[STAT_OVF_BIT]     = ovf_q;
            end
            default:   rd_word = '0;
        endcase
        readdata_d = rd_en ? rd_word : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            mask_q     <= '0;
            edge_cap_q <= '0;
            ovf_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            prev_q     <= sync_w;
            mask_q     <= mask_d;
            edge_cap_q <= edge_cap_d;
            ovf_q      <= ovf_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & mask_q);

endmodule
